// File: rtl/uart_regs_pkg.sv
// rtl/uart_regs_pkg.sv - register offsets, status bits, response codes and TX state type
package uart_regs_pkg;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_BAUDDIV = 4'h4;
  localparam logic [3:0] OFF_STATUS  = 4'h8;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_OVERRUN = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Misalignment is checked before the window so 0x0D reports SLVERR, not DECERR.
  function automatic logic [1:0] addr_resp(input logic [3:0] addr);
    if (addr[1:0] != 2'b00) return RESP_SLVERR;
    if (addr >= 4'hC)       return RESP_DECERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - 8N1 shift engine, LSB first, bit period div+1 clocks
module uart_tx_core
  import uart_regs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [7:0]  byte_in,
  input  logic [15:0] div_in,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  tx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        bit_end;

  assign bit_end = (cnt_q == div_q);
  // Last cycle of the stop bit: a load here chains the next frame with no idle gap.
  assign done    = (state_q == STOP) && bit_end;
  assign busy    = busy_q;
  assign tx      = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    if (state_q != IDLE) cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
    case (state_q)
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = 3'd0;
        tx_d    = shreg_q[0];
      end
      DATA: if (bit_end) begin
        if (idx_q == 3'd7) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          idx_d   = idx_q + 3'd1;
          shreg_d = {1'b0, shreg_q[7:1]};
          tx_d    = shreg_q[1];
        end
      end
      STOP: if (bit_end) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
      default: ;
    endcase
    if (load && ((state_q == IDLE) || done)) begin
      state_d = START;
      cnt_d   = 16'd0;
      div_d   = div_in;
      idx_d   = 3'd0;
      shreg_d = byte_in;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      div_q   <= 16'd0;
      idx_q   <= 3'd0;
      shreg_q <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/axi_lite_uart_tx.sv
// rtl/axi_lite_uart_tx.sv - AXI-Lite register slave driving an 8N1 UART transmitter
module axi_lite_uart_tx
  import uart_regs_pkg::*;
#(
  parameter int          AW          = 32,
  parameter int          DW          = 32,
  parameter logic [15:0] BAUDDIV_RST = 16'd867
) (
  input  logic            ACLK,
  input  logic            ARESETn,
  input  logic [AW-1:0]   S_AWADDR,
  input  logic            S_AWVALID,
  output logic            S_AWREADY,
  input  logic [DW-1:0]   S_WDATA,
  input  logic [DW/8-1:0] S_WSTRB,
  input  logic            S_WVALID,
  output logic            S_WREADY,
  output logic [1:0]      S_BRESP,
  output logic            S_BVALID,
  input  logic            S_BREADY,
  input  logic [AW-1:0]   S_ARADDR,
  input  logic            S_ARVALID,
  output logic            S_ARREADY,
  output logic [DW-1:0]   S_RDATA,
  output logic [1:0]      S_RRESP,
  output logic            S_RVALID,
  input  logic            S_RREADY,
  output logic            uart_tx
);

  logic          aw_held_q, aw_held_d;
  logic [3:0]    awaddr_q, awaddr_d;
  logic          w_held_q, w_held_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [1:0]    wstrb_q, wstrb_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          rvalid_q, rvalid_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [15:0]   bauddiv_q, bauddiv_d;
  logic          overrun_q, overrun_d;
  logic          commit, overrun_set, core_load, tx_busy, tx_done;
  logic [1:0]    wr_resp, rd_resp;
  logic          unused_bits;

  assign unused_bits = ^{S_AWADDR[AW-1:4], S_ARADDR[AW-1:4], S_WDATA[DW-1:16], S_WSTRB[DW/8-1:2]};

  assign S_AWREADY = !aw_held_q && !bvalid_q;
  assign S_WREADY  = !w_held_q && !bvalid_q;
  assign S_ARREADY = !rvalid_q;
  assign S_BVALID  = bvalid_q;
  assign S_BRESP   = bresp_q;
  assign S_RVALID  = rvalid_q;
  assign S_RRESP   = rresp_q;
  assign S_RDATA   = rdata_q;
  assign commit    = aw_held_q && w_held_q && !bvalid_q;
  assign wr_resp   = addr_resp(awaddr_q);
  assign rd_resp   = addr_resp(S_ARADDR[3:0]);

  always_comb begin
    aw_held_d   = aw_held_q;
    awaddr_d    = awaddr_q;
    w_held_d    = w_held_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    bauddiv_d   = bauddiv_q;
    overrun_d   = overrun_q;
    overrun_set = 1'b0;
    core_load   = 1'b0;
    if (S_AWVALID && S_AWREADY) begin
      aw_held_d = 1'b1;
      awaddr_d  = S_AWADDR[3:0];
    end
    if (S_WVALID && S_WREADY) begin
      w_held_d = 1'b1;
      wdata_d  = S_WDATA[15:0];
      wstrb_d  = S_WSTRB[1:0];
    end
    if (bvalid_q && S_BREADY) bvalid_d = 1'b0;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_resp;
      if (wr_resp == RESP_OKAY) begin
        case (awaddr_q)
          OFF_TXDATA: if (wstrb_q[0]) begin
            // A frame finishing this very cycle counts as free.
            if (!tx_busy || tx_done) core_load = 1'b1;
            else begin
              bresp_d     = RESP_SLVERR;
              overrun_set = 1'b1;
            end
          end
          OFF_BAUDDIV: begin
            if (wstrb_q[0]) bauddiv_d[7:0]  = wdata_q[7:0];
            if (wstrb_q[1]) bauddiv_d[15:8] = wdata_q[15:8];
          end
          OFF_STATUS: if (wstrb_q[0] && wdata_q[STAT_OVERRUN]) overrun_d = 1'b0;
          default: ;
        endcase
      end
    end
    if (overrun_set) overrun_d = 1'b1;
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rvalid_q && S_RREADY) rvalid_d = 1'b0;
    if (S_ARVALID && S_ARREADY) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_resp;
      rdata_d  = '0;
      if (rd_resp == RESP_OKAY) begin
        case (S_ARADDR[3:0])
          OFF_BAUDDIV: rdata_d[15:0] = bauddiv_q;
          OFF_STATUS: begin
            rdata_d[STAT_BUSY]    = tx_busy;
            rdata_d[STAT_OVERRUN] = overrun_q;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= 4'd0;
      w_held_q  <= 1'b0;
      wdata_q   <= 16'd0;
      wstrb_q   <= 2'd0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      bauddiv_q <= BAUDDIV_RST;
      overrun_q <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      bauddiv_q <= bauddiv_d;
      overrun_q <= overrun_d;
    end
  end

  uart_tx_core u_core (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .load    (core_load),
    .byte_in (wdata_q[7:0]),
    .div_in  (bauddiv_q),
    .busy    (tx_busy),
    .done    (tx_done),
    .tx      (uart_tx)
  );

endmodule

// File: tb/tb_axi_lite_uart_tx.sv
// tb/tb_axi_lite_uart_tx.sv - scoreboard bench for axi_lite_uart_tx
module tb_axi_lite_uart_tx;

  logic        clk;
  logic        ARESETn;
  logic [31:0] S_AWADDR;
  logic        S_AWVALID, S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WVALID, S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID, S_BREADY;
  logic [31:0] S_ARADDR;
  logic        S_ARVALID, S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID, S_RREADY;
  logic        uart_tx;

  axi_lite_uart_tx #(.AW(32), .DW(32), .BAUDDIV_RST(16'd867)) dut (
    .ACLK(clk), .ARESETn(ARESETn),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .uart_tx(uart_tx)
  );

  typedef struct {
    logic [31:0] d;
    logic [31:0] m;
    logic [1:0]  r;
  } rexp_t;

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  int          errors = 0;
  int          checks = 0;
  int          cyc_n  = 0;
  int          cur_div = 867;
  logic [1:0]  exp_b[$];
  rexp_t       exp_r[$];
  logic [7:0]  exp_byte[$];
  int          frame_starts[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc_n);
  endtask

  task automatic wait_cycle(input int n);
    while (cyc_n < n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (ARESETn && S_BVALID && S_BREADY) begin
      if (exp_b.size() == 0) fail_now("unexpected_b");
      else chk("bresp", {30'd0, S_BRESP}, {30'd0, exp_b.pop_front()});
    end
    if (ARESETn && S_RVALID && S_RREADY) begin
      if (exp_r.size() == 0) fail_now("unexpected_r");
      else begin
        rexp_t e;
        e = exp_r.pop_front();
        chk("rdata", S_RDATA & e.m, e.d & e.m);
        chk("rresp", {30'd0, S_RRESP}, {30'd0, e.r});
      end
    end
  end

  // Serial line monitor: every clock of every bit must hold the bit's value.
  initial begin
    logic       prev;
    logic [9:0] bits;
    logic       glitch;
    int         p;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (ARESETn && prev && !uart_tx) begin
        p = cur_div + 1;
        glitch = 1'b0;
        frame_starts.push_back(cyc_n);
        for (int b = 0; b < 10; b++) begin
          for (int j = 0; j < p; j++) begin
            if (b != 0 || j != 0) @(negedge clk);
            if (j == 0) bits[b] = uart_tx;
            else if (uart_tx !== bits[b]) glitch = 1'b1;
          end
        end
        chk("frame_fmt", {29'd0, glitch, bits[9], bits[0]}, 32'b010);
        if (exp_byte.size() == 0) fail_now("frame_extra");
        else chk("frame_byte", {24'd0, bits[8:1]}, {24'd0, exp_byte.pop_front()});
      end
      prev = uart_tx;
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] resp, input int aw_delay = 0, input int b_delay = 0);
    bit aw_d, w_d, b_d;
    int n, bv_cnt;
    aw_d = 0; w_d = 0; b_d = 0; n = 0; bv_cnt = 0;
    exp_b.push_back(resp);
    S_AWADDR = addr; S_WDATA = data; S_WSTRB = strb; S_WVALID = 1'b1;
    S_AWVALID = 1'b0; S_BREADY = (b_delay == 0);
    while (!b_d && n < 200) begin
      if (!aw_d && n >= aw_delay) S_AWVALID = 1'b1;
      if (S_BVALID && bv_cnt >= b_delay) S_BREADY = 1'b1;
      @(negedge clk);
      if (S_BVALID && !S_BREADY) chk("bresp_hold", {30'd0, S_BRESP}, {30'd0, resp});
      if (S_AWVALID && S_AWREADY) aw_d = 1;
      if (S_WVALID && S_WREADY) w_d = 1;
      if (S_BVALID && S_BREADY) b_d = 1;
      if (S_BVALID) bv_cnt++;
      @(posedge clk); #1;
      if (aw_d) S_AWVALID = 1'b0;
      if (w_d) S_WVALID = 1'b0;
      n++;
    end
    S_BREADY = 1'b0; S_AWVALID = 1'b0; S_WVALID = 1'b0;
    if (!b_d) fail_now("write_timeout");
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] mask,
                          input logic [1:0] resp, output logic [31:0] rd);
    bit ar_d, r_d;
    int n;
    rexp_t e;
    ar_d = 0; r_d = 0; n = 0; rd = '0;
    e.d = data; e.m = mask; e.r = resp;
    exp_r.push_back(e);
    S_ARADDR = addr; S_ARVALID = 1'b1; S_RREADY = 1'b1;
    while (!r_d && n < 200) begin
      @(negedge clk);
      if (S_ARVALID && S_ARREADY) ar_d = 1;
      if (S_RVALID && S_RREADY) begin
        r_d = 1;
        rd = S_RDATA;
      end
      @(posedge clk); #1;
      if (ar_d) S_ARVALID = 1'b0;
      n++;
    end
    S_ARVALID = 1'b0; S_RREADY = 1'b0;
    if (!r_d) fail_now("read_timeout");
  endtask

  task automatic rd_chk(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    logic [31:0] rd;
    axi_read(addr, data, 32'hFFFF_FFFF, resp, rd);
  endtask

  task automatic send(input logic [7:0] b);
    exp_byte.push_back(b);
    axi_write(32'h0, {24'd0, b}, 4'hF, OKAY);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pa;
    logic [31:0] rd;
    logic [7:0]  msg [6];
    msg[0] = 8'h48; msg[1] = 8'h45; msg[2] = 8'h4C; msg[3] = 8'h4C; msg[4] = 8'h4F; msg[5] = 8'h0A;
    ARESETn = 1'b0;
    S_AWADDR = '0; S_AWVALID = 1'b0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 1'b0; S_BREADY = 1'b0;
    S_ARADDR = '0; S_ARVALID = 1'b0; S_RREADY = 1'b0;
    repeat (5) @(posedge clk);
    #1 ARESETn = 1'b1;
    @(negedge clk);
    chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_valids", {30'd0, S_BVALID, S_RVALID}, 32'd0);
    chk("rst_readys", {29'd0, S_AWREADY, S_WREADY, S_ARREADY}, 32'd7);
    @(posedge clk); #1;
    rd_chk(32'h8, 32'h0, OKAY);
    rd_chk(32'h4, 32'd867, OKAY);
    rd_chk(32'h0, 32'h0, OKAY);

    rd_chk(32'hC, 32'h0, DECERR);
    rd_chk(32'h5, 32'h0, SLVERR);
    axi_write(32'h5, 32'h0000_00FF, 4'hF, SLVERR);
    axi_write(32'hC, 32'h0000_00FF, 4'hF, DECERR);
    rd_chk(32'h4, 32'd867, OKAY);

    axi_write(32'h4, 32'hFFFF_5577, 4'b0010, OKAY);
    rd_chk(32'h4, 32'h0000_5563, OKAY);

    axi_write(32'h4, 32'd3, 4'hF, OKAY, 3, 5);
    chk("b_single", {31'd0, S_BVALID}, 32'd0);
    cur_div = 3;
    rd_chk(32'h4, 32'd3, OKAY);

    axi_write(32'h0, 32'h41, 4'b1110, OKAY);
    rd_chk(32'h8, 32'h0, OKAY);

    pa = cyc_n;
    send(8'h48);
    axi_write(32'h0, 32'h55, 4'hF, SLVERR);
    rd_chk(32'h8, 32'h3, OKAY);
    axi_write(32'h8, 32'h2, 4'hF, OKAY);
    rd_chk(32'h8, 32'h1, OKAY);
    axi_write(32'h4, 32'd0, 4'hF, OKAY);
    cur_div = 0;
    wait_cycle(pa + 41);
    rd_chk(32'h8, 32'h1, OKAY);
    rd_chk(32'h8, 32'h0, OKAY);

    pa = cyc_n;
    send(8'hC3);
    wait_cycle(pa + 10);
    send(8'h3C);
    repeat (30) @(posedge clk);
    #1;
    if (frame_starts.size() >= 2)
      chk("b2b_gap", frame_starts[frame_starts.size()-1] - frame_starts[frame_starts.size()-2], 32'd10);
    else fail_now("b2b_frames_missing");

    axi_write(32'h4, 32'd3, 4'hF, OKAY);
    cur_div = 3;
    pa = cyc_n;
    fork
      send(8'hA5);
      begin
        wait_cycle(pa + 1);
        rd_chk(32'h8, 32'h0, OKAY);
      end
    join
    wait_cycle(pa + 42);
    rd_chk(32'h8, 32'h0, OKAY);

    for (int i = 0; i < 6; i++) begin
      int polls;
      polls = 0;
      rd = 32'h1;
      while (rd[0] && polls < 500) begin
        axi_read(32'h8, 32'h0, 32'hFFFF_FFFE, OKAY, rd);
        polls++;
      end
      if (rd[0]) fail_now("poll_timeout");
      send(msg[i]);
    end

    for (int i = 0; i < 3000 && exp_byte.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("drain_bytes", exp_byte.size(), 32'd0);
    chk("drain_b", exp_b.size(), 32'd0);
    chk("drain_r", exp_r.size(), 32'd0);
    chk("idle_line", {31'd0, uart_tx}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
